// File: rtl/delay_scan_sequencer_if.sv
// delay_scan_sequencer_if: control and per-link delay-line bundle for the delay scan sequencer.
// err_threshold exists only when DELAY_SCAN_THRESHOLD_EN is defined.
interface delay_scan_sequencer_if #(
  parameter int NLINKS     = 12,
  parameter int DELAY_W    = 9,
  parameter int LINK_IDX_W = 4
);
  logic                      start;
  logic                      abort;
  logic [NLINKS-1:0]         link_mask;
  logic [NLINKS-1:0]         delay_ready;
  logic [NLINKS*16-1:0]      bit_align_errors;
`ifdef DELAY_SCAN_THRESHOLD_EN
  logic [15:0]               err_threshold;
`endif
  logic [NLINKS-1:0]         delay_set;
  logic [NLINKS*DELAY_W-1:0] delay_in;
  logic [NLINKS-1:0]         reset_counters;
  logic [NLINKS*DELAY_W-1:0] best_delay;
  logic [NLINKS-1:0]         link_locked;
  logic [LINK_IDX_W-1:0]     cur_link;
  logic                      busy;
  logic                      done;
  modport master (
    output start, abort, link_mask, delay_ready, bit_align_errors,
`ifdef DELAY_SCAN_THRESHOLD_EN
    output err_threshold,
`endif
    input delay_set, delay_in, reset_counters, best_delay, link_locked, cur_link, busy, done
  );
  modport slave (
    input start, abort, link_mask, delay_ready, bit_align_errors,
`ifdef DELAY_SCAN_THRESHOLD_EN
    input err_threshold,
`endif
    output delay_set, delay_in, reset_counters, best_delay, link_locked, cur_link, busy, done
  );
endinterface

// File: rtl/delay_scan_sequencer.sv
// delay_scan_sequencer: per-link coarse delay sweep picking the centre of the longest error-free window.
// Define DELAY_SCAN_THRESHOLD_EN to accept samples with errors up to err_threshold instead of zero.
module delay_scan_sequencer #(
  parameter int NLINKS        = 12,
  parameter int DELAY_W       = 9,
  parameter int DELAY_STEP    = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 1024,
  parameter int LINK_IDX_W    = 4
) (
  input logic clk160,
  input logic rstb,
  delay_scan_sequencer_if.slave bus
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SELECT    = 4'd1;
  localparam logic [3:0] S_SET       = 4'd2;
  localparam logic [3:0] S_WAIT_RDY  = 4'd3;
  localparam logic [3:0] S_CLEAR     = 4'd4;
  localparam logic [3:0] S_SETTLE    = 4'd5;
  localparam logic [3:0] S_DWELL     = 4'd6;
  localparam logic [3:0] S_SAMPLE    = 4'd7;
  localparam logic [3:0] S_APPLY     = 4'd8;
  localparam logic [3:0] S_APPLY_RDY = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + DWELL_CYCLES + 2);
  localparam logic [DELAY_W:0] D_MAX  = {1'b0, {DELAY_W{1'b1}}};
  localparam logic [DELAY_W:0] D_STEP = (DELAY_W+1)'(DELAY_STEP);
  logic [3:0]                         state;
  logic [CNT_W-1:0]                   cnt;
  logic [DELAY_W-1:0]                 d;
  logic [LINK_IDX_W-1:0]              cur, pick;
  logic [NLINKS-1:0]                  rem, sel, dset, rcnt, locked;
  logic [NLINKS-1:0][DELAY_W-1:0]     din, best;
  logic                               run_open, best_valid, busy_q, done_q;
  logic [DELAY_W-1:0]                 run_first, run_last, best_first, best_last;
  logic [DELAY_W-1:0]                 first_a, last_a, mid;
  logic [15:0]                        errs;
  logic                               pass, at_end, closing, better;
  assign sel  = NLINKS'(1) << cur;
  assign errs = bus.bit_align_errors[16*cur +: 16];
`ifdef DELAY_SCAN_THRESHOLD_EN
  assign pass = errs <= bus.err_threshold;
`else
  assign pass = errs == 16'd0;
`endif
  // The sweep stops before d would pass the top tap, so d never wraps.
  assign at_end  = ({1'b0, d} + D_STEP) > D_MAX;
  assign first_a = (pass && !run_open) ? d : run_first;
  assign last_a  = pass ? d : run_last;
  assign closing = pass ? at_end : run_open;
  // Strictly longer only, so the earliest of equal-length windows survives.
  assign better  = closing && (!best_valid || (last_a - first_a) > (best_last - best_first));
  assign mid     = best_valid ? DELAY_W'(({1'b0, best_first} + {1'b0, best_last}) >> 1) : '0;
  always_comb begin
    pick = '0;
    for (int i = NLINKS - 1; i >= 0; i--) if (rem[i]) pick = LINK_IDX_W'(i);
  end
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state      <= S_IDLE;
      cnt        <= '0;
      d          <= '0;
      cur        <= '0;
      rem        <= '0;
      dset       <= '0;
      rcnt       <= '0;
      locked     <= '0;
      din        <= '0;
      best       <= '0;
      run_open   <= 1'b0;
      run_first  <= '0;
      run_last   <= '0;
      best_valid <= 1'b0;
      best_first <= '0;
      best_last  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      dset   <= '0;
      rcnt   <= '0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (bus.start) begin
            rem    <= bus.link_mask;
            locked <= locked & ~bus.link_mask;
            busy_q <= 1'b1;
            state  <= S_SELECT;
          end
          S_SELECT: if (rem == '0) state <= S_DONE;
          else begin
            cur        <= pick;
            d          <= '0;
            run_open   <= 1'b0;
            run_first  <= '0;
            run_last   <= '0;
            best_valid <= 1'b0;
            best_first <= '0;
            best_last  <= '0;
            state      <= S_SET;
          end
          S_SET: begin
            din[cur] <= d;
            dset     <= sel;
            cnt      <= '0;
            state    <= S_WAIT_RDY;
          end
          S_WAIT_RDY, S_APPLY_RDY: if (cnt != '0 && bus.delay_ready[cur]) begin
            cnt <= '0;
            if (state == S_WAIT_RDY) state <= S_CLEAR;
            else begin
              rem[cur] <= 1'b0;
              state    <= S_SELECT;
            end
          end else cnt <= CNT_W'(1);
          S_CLEAR: begin
            rcnt  <= sel;
            cnt   <= '0;
            state <= S_SETTLE;
          end
          S_SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_DWELL;
          end else cnt <= cnt + 1'b1;
          S_DWELL: if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else cnt <= cnt + 1'b1;
          S_SAMPLE: begin
            run_open  <= pass && !at_end;
            run_first <= first_a;
            run_last  <= last_a;
            if (better) begin
              best_valid <= 1'b1;
              best_first <= first_a;
              best_last  <= last_a;
            end
            if (at_end) state <= S_APPLY;
            else begin
              d     <= d + DELAY_W'(DELAY_STEP);
              state <= S_SET;
            end
          end
          S_APPLY: begin
            best[cur]   <= mid;
            din[cur]    <= mid;
            locked[cur] <= best_valid;
            dset        <= sel;
            cnt         <= '0;
            state       <= S_APPLY_RDY;
          end
          S_DONE: begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
  assert property (@(posedge clk160) disable iff (!rstb) $onehot0({dset, rcnt}));
  assign bus.delay_set      = dset;
  assign bus.delay_in       = din;
  assign bus.reset_counters = rcnt;
  assign bus.best_delay     = best;
  assign bus.link_locked    = locked;
  assign bus.cur_link       = cur;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_delay_scan_sequencer.sv
// tb_delay_scan_sequencer: directed scans with a done-triggered scoreboard of per-link results and strobe counts.
module tb_delay_scan_sequencer;
  localparam int NL = 12;
  localparam int DW = 9;
  localparam int LW = 4;
  localparam int K_BEST = 0, K_LOCK = 1, K_DIN = 2, K_NSET = 3, K_NRST = 4;
  localparam int K_FIRST = 5, K_LAST = 6, K_FD = 7, K_TOT = 8, K_BUSY = 9;
  typedef struct {int scan; int kind; int link; int val;} exp_t;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic rdy_en = 1'b1;
  int errors = 0, checks = 0, scan_id = 0, dones = 0;
  int wlo0[NL], whi0[NL], wlo1[NL], whi1[NL];
  int nset[NL], nrst[NL];
  int first_link = -1, last_link = -1, first_d = -1;
  exp_t q[$];
  always #5 clk = ~clk;
  delay_scan_sequencer_if #(.NLINKS(NL), .DELAY_W(DW), .LINK_IDX_W(LW)) bus();
  delay_scan_sequencer #(
    .NLINKS(NL), .DELAY_W(DW), .DELAY_STEP(8), .SETTLE_CYCLES(2), .DWELL_CYCLES(4), .LINK_IDX_W(LW)
  ) dut (.clk160(clk), .rstb(rstb), .bus(bus));
  assign bus.delay_ready = {NL{rdy_en}};
`ifdef DELAY_SCAN_THRESHOLD_EN
  assign bus.err_threshold = 16'd0;
`endif
  // Link model: zero errors while the programmed delay sits inside one of the link's windows.
  always @(negedge clk)
    for (int i = 0; i < NL; i++) begin
      int v;
      v = int'(bus.delay_in[i*DW +: DW]);
      bus.bit_align_errors[i*16 +: 16] =
        ((v >= wlo0[i] && v <= whi0[i]) || (v >= wlo1[i] && v <= whi1[i])) ? 16'd0 : 16'd7;
    end
  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  function automatic string kname(int k);
    case (k)
      K_BEST:  return "best_delay";
      K_LOCK:  return "link_locked";
      K_DIN:   return "delay_in";
      K_NSET:  return "delay_set_count";
      K_NRST:  return "reset_counters_count";
      K_FIRST: return "first_link";
      K_LAST:  return "last_link";
      K_FD:    return "first_delay";
      K_TOT:   return "total_strobes";
      default: return "busy_at_done";
    endcase
  endfunction
  task automatic clear_counts();
    for (int i = 0; i < NL; i++) begin
      nset[i] = 0;
      nrst[i] = 0;
    end
    first_link = -1;
    last_link  = -1;
    first_d    = -1;
  endtask
  initial begin
    clear_counts();
    forever begin
      @(negedge clk);
      if (rstb) begin
        if (bus.abort) clear_counts();
        for (int i = 0; i < NL; i++) begin
          nset[i] += int'(bus.delay_set[i]);
          nrst[i] += int'(bus.reset_counters[i]);
        end
        if (|bus.delay_set) begin
          chk("delay_set_on_cur_link", int'(bus.delay_set), 1 << bus.cur_link);
          if (first_link < 0) begin
            first_link = int'(bus.cur_link);
            first_d    = int'(bus.delay_in[int'(bus.cur_link)*DW +: DW]);
          end
          last_link = int'(bus.cur_link);
        end
        if (|bus.reset_counters) chk("reset_counters_on_cur_link", int'(bus.reset_counters), 1 << bus.cur_link);
        if (bus.done) begin
          dones++;
          if (q.size() == 0 || q[0].scan != dones) chk("unexpected_done", 1, 0);
          while (q.size() > 0 && q[0].scan == dones) begin
            exp_t e;
            int act, tot;
            e = q.pop_front();
            tot = 0;
            for (int i = 0; i < NL; i++) tot += nset[i] + nrst[i];
            case (e.kind)
              K_BEST:  act = int'(bus.best_delay[e.link*DW +: DW]);
              K_LOCK:  act = int'(bus.link_locked[e.link]);
              K_DIN:   act = int'(bus.delay_in[e.link*DW +: DW]);
              K_NSET:  act = nset[e.link];
              K_NRST:  act = nrst[e.link];
              K_FIRST: act = first_link;
              K_LAST:  act = last_link;
              K_FD:    act = first_d;
              K_TOT:   act = tot;
              default: act = int'(bus.busy);
            endcase
            chk($sformatf("scan%0d %s[%0d]", e.scan, kname(e.kind), e.link), act, e.val);
          end
          clear_counts();
        end
      end
    end
  end
  task automatic push(int k, int l, int v);
    q.push_back('{scan_id, k, l, v});
  endtask
  task automatic pulse_start(logic [NL-1:0] m);
    bus.link_mask = m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask
  task automatic wait_set(int link, int cnt, string nm);
    int n, k;
    n = 0;
    k = 0;
    while (k < cnt && n < 5000) begin
      @(negedge clk);
      n++;
      if (bus.delay_set[link]) k++;
    end
    chk(nm, k, cnt);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int rc, dn;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.link_mask = '0;
    for (int i = 0; i < NL; i++) begin
      wlo0[i] = 1; whi0[i] = 0; wlo1[i] = 1; whi1[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_delay_in", int'(|bus.delay_in), 0);
    chk("reset_best_delay", int'(|bus.best_delay), 0);
    chk("reset_locked", int'(|bus.link_locked), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rstb = 1'b1;
    @(posedge clk); #1;
    chk("idle_strobes", int'(|{bus.delay_set, bus.reset_counters, bus.done}), 0);
    // Single window 80..200 on link 0.
    wlo0[0] = 80; whi0[0] = 200;
    scan_id++;
    push(K_BEST, 0, 140); push(K_LOCK, 0, 1); push(K_DIN, 0, 140);
    push(K_NSET, 0, 65); push(K_NRST, 0, 64); push(K_NSET, 1, 0); push(K_BUSY, 0, 0);
    pulse_start(12'h001);
    wait_done();
    // Links 0 and 2; link 2 has two equal windows, the earlier must win.
    wlo0[0] = 240; whi0[0] = 256;
    wlo0[2] = 16; whi0[2] = 48; wlo1[2] = 320; whi1[2] = 352;
    scan_id++;
    push(K_BEST, 0, 248); push(K_BEST, 2, 32); push(K_LOCK, 2, 1);
    push(K_FIRST, 0, 0); push(K_LAST, 0, 2); push(K_NSET, 2, 65);
    pulse_start(12'h005);
    wait_done();
    // Window touching the top of the sweep on link 1.
    wlo0[1] = 400; whi0[1] = 504;
    scan_id++;
    push(K_BEST, 1, 452); push(K_LOCK, 1, 1); push(K_DIN, 1, 452);
    pulse_start(12'h002);
    wait_done();
    // Link 1 never error-free; unmasked links keep their results.
    wlo0[1] = 1; whi0[1] = 0;
    scan_id++;
    push(K_BEST, 1, 0); push(K_LOCK, 1, 0); push(K_DIN, 1, 0);
    push(K_BEST, 0, 248); push(K_LOCK, 0, 1); push(K_BEST, 2, 32);
    pulse_start(12'h002);
    wait_done();
    // Abort during the dwell of step 10 on link 3.
    wlo0[3] = 0; whi0[3] = 100;
    pulse_start(12'h008);
    wait_set(3, 10, "abort_reach_step10");
    repeat (6) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_strobes", int'(|{bus.delay_set, bus.reset_counters}), 0);
    chk("abort_delay_in3", int'(bus.delay_in[3*DW +: DW]), 72);
    chk("abort_locked3", int'(bus.link_locked[3]), 0);
    dn = 0;
    rc = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(bus.done);
      rc += int'(|bus.delay_set);
    end
    chk("abort_no_done", dn, 0);
    chk("abort_idle_no_strobe", rc, 0);
    @(posedge clk); #1;
    scan_id++;
    push(K_FD, 3, 0); push(K_BEST, 3, 48); push(K_LOCK, 3, 1); push(K_NSET, 3, 65);
    pulse_start(12'h008);
    wait_done();
    // delay_ready held low: no clear, start pulses ignored.
    rdy_en = 1'b0;
    wlo0[4] = 8; whi0[4] = 8;
    scan_id++;
    push(K_BEST, 4, 8); push(K_LOCK, 4, 1); push(K_NSET, 4, 65);
    push(K_NRST, 4, 64); push(K_NSET, 5, 0); push(K_NSET, 0, 0);
    pulse_start(12'h010);
    wait_set(4, 1, "ready_low_first_set");
    rc = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      bus.start = (i == 100 || i == 300);
      bus.link_mask = 12'hFFF;
      @(negedge clk);
      rc += int'(|bus.reset_counters);
    end
    bus.start = 1'b0;
    chk("ready_low_no_clear", rc, 0);
    chk("ready_low_busy", int'(bus.busy), 1);
    chk("ready_low_cur_link", int'(bus.cur_link), 4);
    rdy_en = 1'b1;
    wait_done();
    // Empty mask: done with no strobes.
    scan_id++;
    push(K_TOT, 0, 0); push(K_BUSY, 0, 0);
    pulse_start(12'h000);
    wait_done();
    repeat (3) @(posedge clk);
    chk("pending_expectations", q.size(), 0);
    chk("done_count", dones, scan_id);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
